// File: rtl/router_pkt_rx.sv
// Router output-port receiver: reads header/payload/parity bytes from the router FIFO,
// streams payload through a 2-entry buffer and reports per-packet status on pkt_done.
module router_pkt_rx #(
   parameter logic [1:0] PORT_ADDR = 2'd0,
   parameter int         TIMEOUT   = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       vld_out,
   input  logic [7:0] data_out,
   output logic       read_enb,
   output logic       pay_valid,
   output logic [7:0] pay_data,
   output logic       pay_last,
   input  logic       sink_ready,
   output logic       pkt_done,
   output logic [5:0] pkt_len,
   output logic [1:0] pkt_addr,
   output logic       par_err,
   output logic       addr_err,
   output logic       tmo_err
);

   typedef enum logic [2:0] {IDLE, HDR, PAY, PAR, DONE} state_t;

   localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

   state_t      state;
   logic        rd_pending;
   logic [1:0]  occ;
   logic [5:0]  rd_cnt;
   logic [5:0]  land_cnt;
   logic [7:0]  parity;
   logic        par_rd_done;
   logic        par_landed;
   logic [15:0] tmo_cnt;
   logic [7:0]  head_data;
   logic [7:0]  tail_data;
   logic        head_last;
   logic        tail_last;

   logic        need_read;
   logic        pop;
   logic [2:0]  fill;
   logic        room;
   logic        pay_land;
   logic        par_land;
   logic        land_last;
   logic        tmo_stall;
   logic        tmo_hit;

   assign pay_valid = (occ != 2'd0);
   assign pay_data  = head_data;
   assign pay_last  = head_last;
   assign pop       = pay_valid & sink_ready;

   always_comb begin
      need_read = 1'b0;
      case (state)
         IDLE:    need_read = 1'b1;
         PAY:     need_read = 1'b1;
         PAR:     need_read = !par_rd_done;
         default: need_read = 1'b0;
      endcase
   end

   // A read issued now lands next cycle, so count in-flight bytes against the 2 buffer slots.
   assign fill      = {1'b0, occ} + {2'b00, rd_pending} - {2'b00, pop};
   assign room      = (fill < 3'd2);
   assign read_enb  = !reset && vld_out && need_read && room;

   assign pay_land  = rd_pending && ((state == PAY) || (state == PAR)) && (land_cnt != pkt_len);
   assign par_land  = rd_pending && (state == PAR) && (land_cnt == pkt_len);
   assign land_last = (land_cnt == (pkt_len - 6'd1));
   assign tmo_stall = ((state == PAY) || (state == PAR)) && need_read && !vld_out;
   assign tmo_hit   = tmo_stall && (tmo_cnt == (TMO_LIMIT - 16'd1));

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         rd_pending  <= 1'b0;
         occ         <= 2'd0;
         rd_cnt      <= 6'd0;
         land_cnt    <= 6'd0;
         parity      <= 8'd0;
         par_rd_done <= 1'b0;
         par_landed  <= 1'b0;
         tmo_cnt     <= 16'd0;
         head_data   <= 8'd0;
         tail_data   <= 8'd0;
         head_last   <= 1'b0;
         tail_last   <= 1'b0;
         pkt_done    <= 1'b0;
         pkt_len     <= 6'd0;
         pkt_addr    <= 2'd0;
         par_err     <= 1'b0;
         addr_err    <= 1'b0;
         tmo_err     <= 1'b0;
      end else begin
         rd_pending <= read_enb;
         pkt_done   <= 1'b0;
         tmo_cnt    <= tmo_stall ? (tmo_cnt + 16'd1) : 16'd0;

         // Parity follows every landed payload byte, whether or not the sink takes it yet.
         if (pay_land) begin
            parity   <= parity ^ data_out;
            land_cnt <= land_cnt + 6'd1;
         end

         case (occ)
            2'd0: begin
               if (pay_land) begin
                  head_data <= data_out;
                  head_last <= land_last;
                  occ       <= 2'd1;
               end
            end
            2'd1: begin
               if (pay_land && pop) begin
                  head_data <= data_out;
                  head_last <= land_last;
               end else if (pay_land) begin
                  tail_data <= data_out;
                  tail_last <= land_last;
                  occ       <= 2'd2;
               end else if (pop) begin
                  occ <= 2'd0;
               end
            end
            default: begin
               if (pop) begin
                  head_data <= tail_data;
                  head_last <= tail_last;
                  if (pay_land) begin
                     tail_data <= data_out;
                     tail_last <= land_last;
                  end else begin
                     occ <= 2'd1;
                  end
               end
            end
         endcase

         case (state)
            IDLE: begin
               if (read_enb) state <= HDR;
            end
            HDR: begin
               pkt_len     <= data_out[7:2];
               pkt_addr    <= data_out[1:0];
               parity      <= data_out;
               addr_err    <= (data_out[1:0] != PORT_ADDR);
               par_err     <= 1'b0;
               tmo_err     <= 1'b0;
               rd_cnt      <= 6'd0;
               land_cnt    <= 6'd0;
               par_rd_done <= 1'b0;
               par_landed  <= 1'b0;
               state       <= (data_out[7:2] != 6'd0) ? PAY : PAR;
            end
            PAY: begin
               if (read_enb) begin
                  rd_cnt <= rd_cnt + 6'd1;
                  if (rd_cnt == (pkt_len - 6'd1)) state <= PAR;
               end
            end
            PAR: begin
               if (read_enb) par_rd_done <= 1'b1;
               if (par_land) begin
                  par_err    <= (parity != data_out);
                  par_landed <= 1'b1;
               end
               if (par_landed && (occ == 2'd0)) begin
                  state    <= DONE;
                  pkt_done <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         // A starved packet is abandoned: buffered payload is dropped and status reported.
         if (tmo_hit) begin
            tmo_err  <= 1'b1;
            occ      <= 2'd0;
            state    <= DONE;
            pkt_done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_router_pkt_rx.sv
// Randomized bench for router_pkt_rx: a queue-based FIFO source and sink feed the DUT while
// a packet-level model predicts payload beats, read counts and per-packet status.
module tb_router_pkt_rx;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       vld_out = 1'b0;
   logic [7:0] data_out = 8'd0;
   logic       read_enb;
   logic       pay_valid;
   logic [7:0] pay_data;
   logic       pay_last;
   logic       sink_ready = 1'b0;
   logic       pkt_done;
   logic [5:0] pkt_len;
   logic [1:0] pkt_addr;
   logic       par_err;
   logic       addr_err;
   logic       tmo_err;

   router_pkt_rx #(.PORT_ADDR(2'd0), .TIMEOUT(16)) dut (
      .clock(clock), .reset(reset), .vld_out(vld_out), .data_out(data_out),
      .read_enb(read_enb), .pay_valid(pay_valid), .pay_data(pay_data), .pay_last(pay_last),
      .sink_ready(sink_ready), .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_addr(pkt_addr),
      .par_err(par_err), .addr_err(addr_err), .tmo_err(tmo_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [5:0] len;
      logic [1:0] addr;
      logic       par;
      logic       aerr;
      logic       terr;
   } res_t;

   logic [7:0] src_q[$];
   logic [7:0] exp_data[$];
   logic       exp_last[$];
   res_t       exp_res[$];

   int checks_total = 0;
   int checks_passed = 0;
   int done_cnt = 0;
   int beat_cnt = 0;
   int rd_count = 0;
   int ready_mode = 0;
   int gap_mode = 0;
   int ready_phase = 0;
   logic rd_seen = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks_total++;
      if (observed === expected) checks_passed++;
      else $display("[TB] FAIL %s: observed %0h, required %0h", tag, observed, expected);
   endtask

   // FIFO model with registered read: a strobe seen this cycle presents its byte after the next edge.
   always begin
      @(negedge clock);
      rd_seen = read_enb;
      if (read_enb) rd_count++;
      @(posedge clock);
      #1;
      if (rd_seen && src_q.size() != 0) data_out = src_q.pop_front();
      vld_out = (src_q.size() != 0) && (gap_mode == 0 || $urandom_range(0, 3) != 0);
      case (ready_mode)
         0: sink_ready = 1'b1;
         1: begin
            sink_ready  = (ready_phase == 0);
            ready_phase = (ready_phase + 1) % 3;
         end
         default: sink_ready = 1'($urandom_range(0, 1));
      endcase
   end

   logic       prev_stall = 1'b0;
   logic       prev_done = 1'b0;
   logic [7:0] prev_data = 8'd0;
   logic       prev_last = 1'b0;
   res_t       mon_res;

   always @(negedge clock) begin
      if (reset) begin
         prev_stall = 1'b0;
         prev_done  = 1'b0;
      end else begin
         if (prev_stall) begin
            checkOutput("hold_valid", 32'(pay_valid), 32'd1);
            checkOutput("hold_data", 32'(pay_data), 32'(prev_data));
            checkOutput("hold_last", 32'(pay_last), 32'(prev_last));
         end
         if (pay_valid && sink_ready) begin
            beat_cnt++;
            checkOutput("beat_expected", 32'(exp_data.size() != 0), 32'd1);
            if (exp_data.size() != 0) begin
               checkOutput("pay_data", 32'(pay_data), 32'(exp_data.pop_front()));
               checkOutput("pay_last", 32'(pay_last), 32'(exp_last.pop_front()));
            end
         end
         if (prev_done) checkOutput("done_pulse", 32'(pkt_done), 32'd0);
         if (pkt_done) begin
            checkOutput("done_expected", 32'(exp_res.size() != 0), 32'd1);
            if (exp_res.size() != 0) begin
               mon_res = exp_res.pop_front();
               checkOutput("pkt_len", 32'(pkt_len), 32'(mon_res.len));
               checkOutput("pkt_addr", 32'(pkt_addr), 32'(mon_res.addr));
               checkOutput("par_err", 32'(par_err), 32'(mon_res.par));
               checkOutput("addr_err", 32'(addr_err), 32'(mon_res.aerr));
               checkOutput("tmo_err", 32'(tmo_err), 32'(mon_res.terr));
            end
            done_cnt++;
         end
         prev_stall = pay_valid && !sink_ready;
         prev_data  = pay_data;
         prev_last  = pay_last;
         prev_done  = pkt_done;
      end
   end

   // trunc < 0 sends the whole packet; otherwise only the header and trunc payload bytes exist.
   task automatic sendPacket(input int len, input logic [1:0] addr, input bit corrupt, input int trunc);
      logic [7:0] hdr;
      logic [7:0] par;
      logic [7:0] b;
      res_t r;
      rd_count = 0;
      hdr = {6'(len), addr};
      par = hdr;
      src_q.push_back(hdr);
      for (int i = 0; i < len; i++) begin
         b   = 8'($urandom);
         par = par ^ b;
         if (trunc < 0 || i < trunc) begin
            src_q.push_back(b);
            exp_data.push_back(b);
            exp_last.push_back(i == len - 1);
         end
      end
      if (trunc < 0) src_q.push_back(corrupt ? (par ^ 8'h01) : par);
      r.len  = 6'(len);
      r.addr = addr;
      r.aerr = (addr != 2'd0);
      r.terr = (trunc >= 0);
      r.par  = (trunc < 0) && corrupt;
      exp_res.push_back(r);
   endtask

   task automatic waitDone(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(posedge clock);
         n++;
      end
      checkOutput("done_seen", 32'(done_cnt >= target), 32'd1);
   endtask

   task automatic applyStimulus(input int len, input logic [1:0] addr, input bit corrupt,
                                input int trunc, input int rmode, input int gmode);
      int target;
      @(posedge clock);
      #2;
      ready_mode = rmode;
      gap_mode   = gmode;
      target     = done_cnt + 1;
      sendPacket(len, addr, corrupt, trunc);
      waitDone(target, 3000);
      @(negedge clock);
      checkOutput("pay_drained", 32'(exp_data.size()), 32'd0);
      checkOutput("read_count", 32'(rd_count), (trunc < 0) ? 32'(len + 2) : 32'(trunc + 1));
   endtask

   task automatic resetDut(input int cycles);
      @(posedge clock);
      #2;
      reset = 1'b1;
      src_q.delete();
      @(posedge clock);
      @(negedge clock);
      checkOutput("rst_read_enb", 32'(read_enb), 32'd0);
      checkOutput("rst_pay_valid", 32'(pay_valid), 32'd0);
      checkOutput("rst_pay_last", 32'(pay_last), 32'd0);
      checkOutput("rst_pkt_done", 32'(pkt_done), 32'd0);
      checkOutput("rst_pkt_len", 32'(pkt_len), 32'd0);
      checkOutput("rst_pkt_addr", 32'(pkt_addr), 32'd0);
      checkOutput("rst_errs", 32'({par_err, addr_err, tmo_err}), 32'd0);
      repeat (cycles) @(posedge clock);
      #2;
      exp_data.delete();
      exp_last.delete();
      exp_res.delete();
      reset = 1'b0;
   endtask

   initial begin
      int base;
      int n;
      int len;
      logic [1:0] addr;
      resetDut(3);

      applyStimulus(16, 2'd0, 1'b0, -1, 0, 0);
      applyStimulus(16, 2'd0, 1'b1, -1, 0, 0);
      applyStimulus(0, 2'd0, 1'b0, -1, 0, 0);
      applyStimulus(5, 2'd0, 1'b0, -1, 1, 0);
      applyStimulus(3, 2'd1, 1'b0, 1, 0, 0);
      applyStimulus(4, 2'd0, 1'b0, -1, 0, 0);

      @(posedge clock);
      #2;
      ready_mode = 0;
      gap_mode   = 0;
      base = beat_cnt;
      sendPacket(16, 2'd0, 1'b0, -1);
      n = 0;
      while (beat_cnt - base < 7 && n < 500) begin
         @(posedge clock);
         n++;
      end
      checkOutput("mid_pkt_beats", 32'(beat_cnt - base), 32'd7);
      resetDut(2);
      applyStimulus(16, 2'd0, 1'b0, -1, 0, 0);

      for (int k = 0; k < 12; k++) begin
         len  = (k == 0) ? 63 : $urandom_range(0, 63);
         addr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         applyStimulus(len, addr, 1'($urandom_range(0, 1)), -1,
                       $urandom_range(0, 2), $urandom_range(0, 1));
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
               checks_passed, checks_total);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
